load_store_unit: RTL

//  Memory-access stage between execute (ALU address) and the word-addressed data memory.

---
 rtl/load_store_unit_if.sv | 29 ++
 rtl/load_store_unit.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit_if.sv
// Request/response and data-memory signals for the load/store unit.
// The master side issues requests and owns the memory read data; the slave side is the LSU.
interface load_store_unit_if;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  opcode;
  logic [31:0] addr;
  logic [31:0] rt_val;
  logic        out_valid;
  logic [31:0] load_data;
  logic        misaligned;
  logic        bad_addr;
  logic [5:0]  mem_opcode;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport master (
    output in_valid, opcode, addr, rt_val, mem_rdata,
    input  in_ready, out_valid, load_data, misaligned, bad_addr,
           mem_opcode, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, opcode, addr, rt_val, mem_rdata,
    output in_ready, out_valid, load_data, misaligned, bad_addr,
           mem_opcode, mem_addr, mem_wdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Memory-access stage: accepts one load/store per handshake, checks alignment and
// range, and drives a word-addressed data memory. Sub-word stores are done as
// read-modify-write; sub-word loads are sign- or zero-extended.
module load_store_unit #(
  parameter int unsigned MEM_WORDS   = 32,
  parameter bit          CHECK_RANGE = 1'b1
) (
  input logic              clk,
  input logic              rst,
  load_store_unit_if.slave bus
);

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RMW_RD,
    S_WRITE,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] rt_q, rt_d;
  logic        mis_q, mis_d;
  logic        bad_q, bad_d;
  logic [31:0] res_q, res_d;
  logic [31:0] wdata_q, wdata_d;

  logic        req_load, req_store, req_mem, req_mis, req_bad;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] word_idx;

  logic        in_ready_c, out_valid_c, mis_c, bad_c;
  logic [5:0]  mem_opcode_c;
  logic [31:0] mem_addr_c, mem_wdata_c, load_data_c;

  // Classify the incoming request; misalignment takes priority over range.
  always_comb begin
    req_load  = 1'b0;
    req_store = 1'b0;
    req_mis   = 1'b0;
    case (bus.opcode)
      OP_LB, OP_LBU: req_load = 1'b1;
      OP_LH, OP_LHU: begin req_load = 1'b1; req_mis = bus.addr[0]; end
      OP_LW:         begin req_load = 1'b1; req_mis = |bus.addr[1:0]; end
      OP_SB:         req_store = 1'b1;
      OP_SH:         begin req_store = 1'b1; req_mis = bus.addr[0]; end
      OP_SW:         begin req_store = 1'b1; req_mis = |bus.addr[1:0]; end
      default:       ;
    endcase
    req_mem = req_load | req_store;
    req_bad = CHECK_RANGE && req_mem && !req_mis &&
              ({2'b00, bus.addr[31:2]} >= 32'(MEM_WORDS));
  end

  // Select the addressed byte/half of the memory read word (little-endian lanes).
  always_comb begin
    word_idx  = {2'b00, addr_q[31:2]};
    lane_byte = 8'h00;
    case (addr_q[1:0])
      2'd0: lane_byte = bus.mem_rdata[7:0];
      2'd1: lane_byte = bus.mem_rdata[15:8];
      2'd2: lane_byte = bus.mem_rdata[23:16];
      2'd3: lane_byte = bus.mem_rdata[31:24];
      default: lane_byte = 8'h00;
    endcase
    lane_half = addr_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
  end

  // Next-state, datapath updates and Moore outputs for the access FSM.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    addr_d       = addr_q;
    rt_d         = rt_q;
    mis_d        = mis_q;
    bad_d        = bad_q;
    res_d        = res_q;
    wdata_d      = wdata_q;
    in_ready_c   = 1'b0;
    out_valid_c  = 1'b0;
    mis_c        = 1'b0;
    bad_c        = 1'b0;
    load_data_c  = '0;
    mem_opcode_c = '0;
    mem_addr_c   = '0;
    mem_wdata_c  = '0;
    case (state_q)
      S_IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          op_d    = bus.opcode;
          addr_d  = bus.addr;
          rt_d    = bus.rt_val;
          mis_d   = req_mis;
          bad_d   = req_bad;
          res_d   = '0;
          wdata_d = bus.rt_val;
          if (req_mis || req_bad || !req_mem) state_d = S_DONE;
          else if (req_load)                  state_d = S_LOAD;
          else if (bus.opcode == OP_SW)       state_d = S_WRITE;
          else                                state_d = S_RMW_RD;
        end
      end
      S_LOAD: begin
        mem_opcode_c = OP_LW;
        mem_addr_c   = word_idx;
        case (op_q)
          OP_LB:   res_d = {{24{lane_byte[7]}}, lane_byte};
          OP_LBU:  res_d = {24'h000000, lane_byte};
          OP_LH:   res_d = {{16{lane_half[15]}}, lane_half};
          OP_LHU:  res_d = {16'h0000, lane_half};
          OP_LW:   res_d = bus.mem_rdata;
          default: res_d = '0;
        endcase
        state_d = S_DONE;
      end
      S_RMW_RD: begin
        mem_opcode_c = OP_LW;
        mem_addr_c   = word_idx;
        wdata_d      = bus.mem_rdata;
        if (op_q == OP_SB) begin
          case (addr_q[1:0])
            2'd0: wdata_d[7:0]   = rt_q[7:0];
            2'd1: wdata_d[15:8]  = rt_q[7:0];
            2'd2: wdata_d[23:16] = rt_q[7:0];
            2'd3: wdata_d[31:24] = rt_q[7:0];
            default: ;
          endcase
        end else if (addr_q[1]) begin
          wdata_d[31:16] = rt_q[15:0];
        end else begin
          wdata_d[15:0] = rt_q[15:0];
        end
        state_d = S_WRITE;
      end
      S_WRITE: begin
        mem_opcode_c = OP_SW;
        mem_addr_c   = word_idx;
        mem_wdata_c  = wdata_q;
        state_d      = S_DONE;
      end
      S_DONE: begin
        out_valid_c = 1'b1;
        mis_c       = mis_q;
        bad_c       = bad_q;
        load_data_c = res_q;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and latched-request registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      rt_q    <= '0;
      mis_q   <= 1'b0;
      bad_q   <= 1'b0;
      res_q   <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      rt_q    <= rt_d;
      mis_q   <= mis_d;
      bad_q   <= bad_d;
      res_q   <= res_d;
      wdata_q <= wdata_d;
    end
  end

  assign bus.in_ready   = in_ready_c;
  assign bus.out_valid  = out_valid_c;
  assign bus.misaligned = mis_c;
  assign bus.bad_addr   = bad_c;
  assign bus.load_data  = load_data_c;
  assign bus.mem_opcode = mem_opcode_c;
  assign bus.mem_addr   = mem_addr_c;
  assign bus.mem_wdata  = mem_wdata_c;

endmodule
